adder_sched: RTL
================

# adder_sched

Scheduler that shares one `adder` instance (SIZE = DATASIZE) between NB_REQ requesters. Each requester presents operands with a valid/ready handshake. The block grants one requester at a time and registers its operands into the shared adder. It returns a registered sum, carry and requester id on a single response channel with backpressure. The block sits between the requesting datapath units and the combinational adder and owns all sequencing of that adder.

## Interface
Parameters:
- DATASIZE, 8, operand/result width; passed to the adder as SIZE.
- NB_REQ, 4, number of requesters, 2..16; IDW = $clog2(NB_REQ).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NB_REQ  bit k: requester k has an operation pending.
- req_ready_o  out  NB_REQ  one-hot or zero; bit k: operands of k accepted this cycle.
- a_i  in  NB_REQ*DATASIZE  operand A of requester k at [k*DATASIZE +: DATASIZE].
- b_i  in  NB_REQ*DATASIZE  operand B, same packing as a_i.
- carry_i  in  NB_REQ  carry-in of requester k.
- res_valid_o  out  1  response available.
- res_ready_i  in  1  consumer accepts the response.
- res_id_o  out  IDW  index of the requester that owns the response.
- result_o  out  DATASIZE  sum.
- carry_o  out  1  carry-out.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid_i bit is set, the arbiter picks index g and drives req_ready_o[g]=1 combinationally in the same cycle.
  - On that edge, a_g, b_g, carry_g and g are captured into operand registers; next state is EXEC.
  - If no request is pending, the FSM stays in IDLE and req_ready_o is 0.
- EXEC:
  - The registered operands drive the adder.
  - The adder outputs are captured into result_o/carry_o and g into res_id_o; next state is RESP.
- RESP:
  - res_valid_o=1.
  - On res_ready_i=1 the FSM returns to IDLE and res_valid_o drops the next cycle.
  - Otherwise it stays in RESP with all response outputs held stable.
- req_ready_o is 0 in EXEC and RESP. No request is accepted while a response is pending.
- Arithmetic: {carry_o, result_o} = a + b + carry_in, computed as a DATASIZE+1 bit sum. Wrap-around is modulo 2^DATASIZE, with the overflow bit on carry_o.
- Round-robin arbitration:
  - Pointer last_g holds the last granted index.
  - The search starts at last_g+1, wrapping NB_REQ-1 -> 0.
  - last_g updates only on acceptance.
- A requester may drop req_valid_i before it is granted; nothing is captured for it.
- Operand inputs are sampled only on the accepting edge.

## Timing
- Reset (async assert, sync release effect):
  - state=IDLE, last_g=NB_REQ-1 (requester 0 wins first).
  - req_ready_o=0, res_valid_o=0, result_o=0, carry_o=0, res_id_o=0.
- Latency: request accepted at edge t -> res_valid_o=1 after edge t+2.
- Throughput: at most one operation per 3 cycles with res_ready_i held 1.
- Simultaneous res_ready_i and new req_valid_i in RESP: the response completes. The new request is granted in the following IDLE cycle, not in RESP.
- Reset during EXEC or RESP: the in-flight operation is discarded with no response, and all outputs take their reset values immediately.
- Holding res_ready_i=0 is legal indefinitely. Requesters keep req_valid_i high and are not lost.

## Configuration
- ADDER_SCHED_FIXED_PRIO_EN
  - Defined: fixed priority. The lowest asserted index always wins, last_g is not implemented, and starvation of high indices is allowed.
  - Undefined (default): round-robin as described under Operation.
- Both variants have identical interface and timing.

## Test plan
- Reset: assert rst_i mid-cycle -> all outputs 0 at once. Release -> IDLE with req_ready_o=0.
- Single op: req 0 with a=200, b=100, carry=0 (DATASIZE=8) -> ready[0] same cycle. Two cycles later result_o=44, carry_o=1, res_id_o=0, res_valid_o=1.
- Round-robin: all 4 valid continuously, res_ready_i=1 -> grant order 0,1,2,3,0. Each result is checked; under FIXED_PRIO_EN the order is 0,0,0,....
- Backpressure: res_ready_i=0 for 5 cycles in RESP -> result_o/res_id_o stable, req_ready_o=0 throughout. Raising res_ready_i -> IDLE next cycle.
- Reset mid-op: req 2 accepted, rst_i pulsed in EXEC -> no response. The next grant goes to the lowest pending index.
- Carry and wrap: a=255, b=0, carry=1 -> result_o=0, carry_o=1. a=0, b=0, carry=0 -> result_o=0, carry_o=0.

Source files
------------

// File: rtl/adder_sched.sv
// adder_sched: shares one combinational adder among NB_REQ valid/ready requesters.
// Define ADDER_SCHED_FIXED_PRIO_EN for fixed-priority arbitration (default: round-robin).

module adder #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  input  logic            carry_i,
  output logic [SIZE-1:0] sum_o,
  output logic            carry_o
);
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SIZE{1'b0}}, carry_i};
endmodule

module adder_sched #(
  parameter int DATASIZE = 8,
  parameter int NB_REQ   = 4,
  parameter int IDW      = $clog2(NB_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NB_REQ-1:0]            req_valid_i,
  output logic [NB_REQ-1:0]            req_ready_o,
  input  logic [NB_REQ*DATASIZE-1:0]   a_i,
  input  logic [NB_REQ*DATASIZE-1:0]   b_i,
  input  logic [NB_REQ-1:0]            carry_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [IDW-1:0]               res_id_o,
  output logic [DATASIZE-1:0]          result_o,
  output logic                         carry_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [DATASIZE-1:0] op_a_q, op_a_d;
  logic [DATASIZE-1:0] op_b_q, op_b_d;
  logic                op_c_q, op_c_d;
  logic [IDW-1:0]      op_id_q, op_id_d;
  logic [DATASIZE-1:0] result_q, result_d;
  logic                carry_q, carry_d;
  logic [IDW-1:0]      res_id_q, res_id_d;

  logic [IDW-1:0]      grant_idx;
  logic                grant_vld;
  logic                accept;
  logic [NB_REQ-1:0]   grant_onehot;
  logic [DATASIZE-1:0] sum;
  logic                cout;

`ifdef ADDER_SCHED_FIXED_PRIO_EN
  // Lowest asserted index wins; scanning downward lets the smallest index overwrite.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] last_g_q, last_g_d;

  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int off);
    int k;
    k = int'(base) + off;
    if (k >= NB_REQ) k = k - NB_REQ;
    return IDW'(k);
  endfunction

  // Scan from farthest to nearest offset so the requester right after last_g wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NB_REQ; i >= 1; i--) begin
      if (req_valid_i[rr_index(last_g_q, i)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_index(last_g_q, i);
      end
    end
  end

  always_comb begin
    last_g_d = last_g_q;
    if (accept) last_g_d = grant_idx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_g_q <= IDW'(NB_REQ - 1);
    else       last_g_q <= last_g_d;
  end
`endif

  assign accept = (state_q == S_IDLE) && grant_vld;

  always_comb begin
    grant_onehot = '0;
    grant_onehot[grant_idx] = 1'b1;
  end

  // Ready is masked during reset so outputs show reset values while rst_i is high.
  assign req_ready_o = (accept && !rst_i) ? grant_onehot : '0;

  adder #(.SIZE(DATASIZE)) u_adder (
    .a_i     (op_a_q),
    .b_i     (op_b_q),
    .carry_i (op_c_q),
    .sum_o   (sum),
    .carry_o (cout)
  );

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_c_d   = op_c_q;
    op_id_d  = op_id_q;
    result_d = result_q;
    carry_d  = carry_q;
    res_id_d = res_id_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_a_d  = a_i[grant_idx*DATASIZE +: DATASIZE];
          op_b_d  = b_i[grant_idx*DATASIZE +: DATASIZE];
          op_c_d  = carry_i[grant_idx];
          op_id_d = grant_idx;
          state_d = S_EXEC;
        end
      end
      // operands registered: capture adder outputs as the response
      S_EXEC: begin
        result_d = sum;
        carry_d  = cout;
        res_id_d = op_id_q;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_c_q   <= 1'b0;
      op_id_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      res_id_q <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_c_q   <= op_c_d;
      op_id_q  <= op_id_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      res_id_q <= res_id_d;
    end
  end

  assign res_valid_o = (state_q == S_RESP);
  assign result_o    = result_q;
  assign carry_o     = carry_q;
  assign res_id_o    = res_id_q;

endmodule
